// File: rtl/bnn_layer_sequencer_if.sv
// Handshake bundle between the layer sequencer and its surroundings:
// host start/busy, the three layer kick/done pairs, the a3 vector and
// the result valid/ready port with its error reporting.
interface bnn_layer_sequencer_if #(
    parameter int NUM_CLASSES = 10
);
    logic                   start;
    logic                   busy;
    logic                   l1_run_EN;
    logic                   l1_done;
    logic                   l2_run_EN;
    logic                   l2_done;
    logic                   l3_run_EN;
    logic                   l3_done;
    logic [NUM_CLASSES-1:0] a3;
    logic                   result_valid;
    logic                   result_ready;
    logic [3:0]             class_idx;
    logic [NUM_CLASSES-1:0] class_vec;
    logic                   no_match;
    logic                   multi_match;
    logic                   timeout_err;
    logic                   err_clr;

    // Sequencer side
    modport master (
        input  start, l1_done, l2_done, l3_done, a3, result_ready, err_clr,
        output busy, l1_run_EN, l2_run_EN, l3_run_EN, result_valid,
               class_idx, class_vec, no_match, multi_match, timeout_err
    );

    // Host / layer-block side
    modport slave (
        output start, l1_done, l2_done, l3_done, a3, result_ready, err_clr,
        input  busy, l1_run_EN, l2_run_EN, l3_run_EN, result_valid,
               class_idx, class_vec, no_match, multi_match, timeout_err
    );
endinterface

// File: rtl/bnn_layer_sequencer.sv
// Schedules the three binarized layers in order, latches the final a3
// vector, reduces it to a class index and offers it on a valid/ready port.
// A per-layer watchdog traps a layer that never signals done.
module bnn_layer_sequencer #(
    parameter int NUM_CLASSES = 10,
    parameter int TIMEOUT     = 1023,
    parameter int TO_W        = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    bnn_layer_sequencer_if.master bus
);

    typedef enum logic [3:0] {
        IDLE, K1, W1, K2, W2, K3, W3, DECIDE, HOLD, ERR
    } state_t;

    localparam logic [TO_W-1:0] TIMEOUT_C = TO_W'(TIMEOUT);

    state_t                 state_reg, state_next;
    logic [TO_W-1:0]        wd_reg, wd_next, wd_inc;
    logic                   done_cur;
    logic                   latch_a3;
    logic                   do_decide;

    logic [NUM_CLASSES-1:0] class_vec_reg;
    logic [3:0]             class_idx_reg;
    logic                   no_match_reg;
    logic                   multi_match_reg;

    logic [3:0]             pe_idx;
    logic                   pe_found;
    logic                   pe_multi;

    assign wd_inc = wd_reg + TO_W'(1);

    // State and watchdog registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            wd_reg    <= '0;
        end else begin
            state_reg <= state_next;
            wd_reg    <= wd_next;
        end
    end

    // Next-state, watchdog and datapath strobes
    always_comb begin
        state_next = state_reg;
        wd_next    = wd_reg;
        latch_a3   = 1'b0;
        do_decide  = 1'b0;
        // Only the done of the layer currently being waited on counts
        done_cur   = ((state_reg == W1) && bus.l1_done) ||
                     ((state_reg == W2) && bus.l2_done) ||
                     ((state_reg == W3) && bus.l3_done);
        case (state_reg)
            IDLE: begin
                if (bus.start) state_next = K1;
            end
            K1: begin
                wd_next    = '0;
                state_next = W1;
            end
            K2: begin
                wd_next    = '0;
                state_next = W2;
            end
            K3: begin
                wd_next    = '0;
                state_next = W3;
            end
            W1, W2, W3: begin
                if (done_cur) begin
                    // done on the final allowed cycle still advances normally
                    case (state_reg)
                        W1:      state_next = K2;
                        W2:      state_next = K3;
                        default: begin
                            state_next = DECIDE;
                            latch_a3   = 1'b1;
                        end
                    endcase
                end else begin
                    wd_next = wd_inc;
                    // Trap once TIMEOUT cycles have been spent waiting
                    if (wd_inc == TIMEOUT_C) state_next = ERR;
                end
            end
            DECIDE: begin
                do_decide  = 1'b1;
                state_next = HOLD;
            end
            HOLD: begin
                if (bus.result_ready) state_next = IDLE;
            end
            ERR: begin
                if (bus.err_clr) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // MSB-first priority encode of the latched vector, plus >=2-bits detect
    always_comb begin
        pe_idx   = 4'hF;
        pe_found = 1'b0;
        pe_multi = 1'b0;
        for (int i = NUM_CLASSES - 1; i >= 0; i--) begin
            if (class_vec_reg[i]) begin
                if (pe_found) pe_multi = 1'b1;
                else          pe_idx   = 4'(NUM_CLASSES - 1 - i);
                pe_found = 1'b1;
            end
        end
    end

    // Result registers; previous result persists until the next DECIDE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            class_vec_reg   <= '0;
            class_idx_reg   <= 4'hF;
            no_match_reg    <= 1'b0;
            multi_match_reg <= 1'b0;
        end else begin
            if (latch_a3) class_vec_reg <= bus.a3;
            if (do_decide) begin
                class_idx_reg   <= pe_idx;
                no_match_reg    <= ~pe_found;
                multi_match_reg <= pe_multi;
            end
        end
    end

    // Status and kick outputs decode straight from the state register
    assign bus.busy         = (state_reg != IDLE);
    assign bus.l1_run_EN    = (state_reg == K1);
    assign bus.l2_run_EN    = (state_reg == K2);
    assign bus.l3_run_EN    = (state_reg == K3);
    assign bus.result_valid = (state_reg == HOLD);
    assign bus.timeout_err  = (state_reg == ERR);
    assign bus.class_idx    = class_idx_reg;
    assign bus.class_vec    = class_vec_reg;
    assign bus.no_match     = no_match_reg;
    assign bus.multi_match  = multi_match_reg;

endmodule

// File: tb/tb_bnn_layer_sequencer.sv
// Directed-vector bench for bnn_layer_sequencer: nominal runs, ties and
// empty vectors, backpressure, watchdog trap/boundary, stray pulses and
// asynchronous reset in the middle of a run.
module tb_bnn_layer_sequencer;

    localparam int NC = 10;
    localparam int TO = 1023;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;
    int   cnt1, cnt2, cnt3;

    bnn_layer_sequencer_if #(.NUM_CLASSES(NC)) bus ();

    bnn_layer_sequencer #(.NUM_CLASSES(NC), .TIMEOUT(TO), .TO_W(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count kick pulses seen at each rising edge
    always @(posedge clk) begin
        if (bus.l1_run_EN) cnt1 <= cnt1 + 1;
        if (bus.l2_run_EN) cnt2 <= cnt2 + 1;
        if (bus.l3_run_EN) cnt3 <= cnt3 + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full image: done pulses d1/d2/d3 cycles after each kick (each >= 3).
    // stray: l3_done in W1 and start in W2. hold: cycles of backpressure.
    task automatic run_image(input string tag, input int d1, input int d2, input int d3,
                             input logic [NC-1:0] a3v, input logic [3:0] e_idx,
                             input logic e_nm, input logic e_mm, input bit stray,
                             input int hold);
        int  s1, s2, s3;
        bit  stable;
        logic [3:0] h_idx;
        s1 = cnt1; s2 = cnt2; s3 = cnt3;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check_eq({tag, ".k1"}, bus.l1_run_EN, 1);
        for (int c = 1; c <= d1; c++) begin
            if (stray && c == 2) bus.l3_done = 1'b1;
            tick();
            bus.l3_done = 1'b0;
        end
        bus.l1_done = 1'b1;
        tick();
        bus.l1_done = 1'b0;
        check_eq({tag, ".k2"}, bus.l2_run_EN, 1);
        for (int c = 1; c <= d2; c++) begin
            if (stray && c == 2) bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
        end
        bus.l2_done = 1'b1;
        tick();
        bus.l2_done = 1'b0;
        check_eq({tag, ".k3"}, bus.l3_run_EN, 1);
        repeat (d3) tick();
        bus.a3      = a3v;
        bus.l3_done = 1'b1;
        tick();
        bus.l3_done = 1'b0;
        bus.a3      = ~a3v;
        check_eq({tag, ".decide_valid"}, bus.result_valid, 0);
        tick();
        check_eq({tag, ".valid"}, bus.result_valid, 1);
        check_eq({tag, ".idx"},   bus.class_idx, e_idx);
        check_eq({tag, ".nm"},    bus.no_match, e_nm);
        check_eq({tag, ".mm"},    bus.multi_match, e_mm);
        check_eq({tag, ".vec"},   bus.class_vec, a3v);
        if (hold > 0) begin
            stable = 1'b1;
            h_idx  = bus.class_idx;
            for (int c = 0; c < hold; c++) begin
                if (c == hold / 2) bus.start = 1'b1;
                tick();
                bus.start = 1'b0;
                if (!bus.result_valid || bus.class_idx !== h_idx ||
                    bus.class_vec !== a3v || bus.l1_run_EN) stable = 1'b0;
            end
            check_eq({tag, ".hold_stable"}, stable, 1);
        end
        // Accept; a simultaneous start must be ignored
        bus.result_ready = 1'b1;
        bus.start        = (hold > 0);
        tick();
        bus.result_ready = 1'b0;
        bus.start        = 1'b0;
        check_eq({tag, ".acc_valid"}, bus.result_valid, 0);
        check_eq({tag, ".acc_busy"},  bus.busy, 0);
        tick();
        check_eq({tag, ".idle_busy"}, bus.busy, 0);
        check_eq({tag, ".n_kicks"}, {cnt1 - s1, cnt2 - s2, cnt3 - s3}, {32'd1, 32'd1, 32'd1});
    endtask

    // Drive layers 1 and 2 and leave the sequencer in the first W3 cycle
    task automatic to_w3();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        bus.l1_done = 1'b1;
        tick();
        bus.l1_done = 1'b0;
        repeat (3) tick();
        bus.l2_done = 1'b1;
        tick();
        bus.l2_done = 1'b0;
        tick();
    endtask

    initial begin
        int s3;
        n_chk = 0; n_err = 0;
        cnt1 = 0; cnt2 = 0; cnt3 = 0;
        bus.start = 0; bus.l1_done = 0; bus.l2_done = 0; bus.l3_done = 0;
        bus.a3 = '0; bus.result_ready = 0; bus.err_clr = 0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        check_eq("rst.busy",  bus.busy, 0);
        check_eq("rst.idx",   bus.class_idx, 4'hF);
        check_eq("rst.valid", bus.result_valid, 0);
        check_eq("rst.err",   bus.timeout_err, 0);
        check_eq("rst.vec",   bus.class_vec, 0);
        check_eq("rst.kicks", {bus.l1_run_EN, bus.l2_run_EN, bus.l3_run_EN}, 0);

        // Nominal, ties, empty, edges
        run_image("nom",   3, 5, 12, 10'b0000100000, 4'd4, 0, 0, 0, 0);
        run_image("tie",   3, 4, 3,  10'b0100010001, 4'd1, 0, 1, 0, 0);
        run_image("empty", 4, 3, 5,  10'b0000000000, 4'hF, 1, 0, 0, 0);
        run_image("msb",   3, 3, 3,  10'b1000000001, 4'd0, 0, 1, 0, 0);
        run_image("lsb",   5, 3, 4,  10'b0000000001, 4'd9, 0, 0, 0, 0);
        // Backpressure with start during HOLD and at the accepting edge
        run_image("bp",    3, 3, 3,  10'b0001000000, 4'd3, 0, 0, 0, 20);
        // Stray l3_done in W1, start in W2
        run_image("stray", 4, 4, 3,  10'b0010000000, 4'd2, 0, 0, 1, 0);

        // Watchdog: withhold l2_done
        s3 = cnt3;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        bus.l1_done = 1'b1;
        tick();
        bus.l1_done = 1'b0;
        check_eq("wd.k2", bus.l2_run_EN, 1);
        tick();                         // first W2 cycle
        repeat (TO - 1) tick();
        check_eq("wd.pre_err", bus.timeout_err, 0);
        tick();
        check_eq("wd.err", bus.timeout_err, 1);
        check_eq("wd.busy", bus.busy, 1);
        repeat (5) tick();
        check_eq("wd.sticky", bus.timeout_err, 1);
        check_eq("wd.no_k3", cnt3 - s3, 0);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        check_eq("wd.clr_err",  bus.timeout_err, 0);
        check_eq("wd.clr_busy", bus.busy, 0);
        run_image("wd_rerun", 3, 3, 3, 10'b0000010000, 4'd5, 0, 0, 0, 0);

        // Watchdog boundary: l2_done on the last allowed W2 cycle
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        bus.l1_done = 1'b1;
        tick();
        bus.l1_done = 1'b0;
        tick();                         // first W2 cycle
        repeat (TO - 1) tick();
        bus.l2_done = 1'b1;
        tick();
        bus.l2_done = 1'b0;
        check_eq("wdb.k3",  bus.l3_run_EN, 1);
        check_eq("wdb.err", bus.timeout_err, 0);
        repeat (3) tick();
        bus.a3 = 10'b0000001000;
        bus.l3_done = 1'b1;
        tick();
        bus.l3_done = 1'b0;
        tick();
        check_eq("wdb.valid", bus.result_valid, 1);
        check_eq("wdb.idx",   bus.class_idx, 4'd6);
        bus.result_ready = 1'b1;
        tick();
        bus.result_ready = 1'b0;
        check_eq("wdb.idle", bus.busy, 0);

        // Asynchronous reset mid-W3
        to_w3();
        check_eq("ar.busy_pre", bus.busy, 1);
        #3;
        rst = 1'b1;
        #1;
        check_eq("ar.busy", bus.busy, 0);
        check_eq("ar.idx",  bus.class_idx, 4'hF);
        check_eq("ar.vec",  bus.class_vec, 0);
        check_eq("ar.valid", bus.result_valid, 0);
        tick();
        tick();
        #2;
        rst = 1'b0;
        tick();
        run_image("ar_rerun", 3, 5, 12, 10'b0000100000, 4'd4, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
